apb_master_ctrl: RTL

APB master sequencer that shares the single APB peripheral interface between two command requesters. It sits on the bridge side in front of `apb_interface`:
- drives its `penable`/`pwrite`/`pselx`/`paddr`/`pwdata` inputs;
- samples the returned `prdata`;
- runs the APB IDLE/SETUP/ACCESS protocol with round-robin arbitration, address decode to three slave selects and a per-transfer response.

---
 rtl/apb_ctrl_pkg.sv | 31 +++
 rtl/apb_master_ctrl_if.sv | 39 +++
 rtl/apb_rr_arbiter.sv | 29 ++
 rtl/apb_master_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types, slave address map and decode helper for the APB master sequencer.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] PSEL_NONE = 3'b000;
  localparam logic [2:0] PSEL_S0   = 3'b001;
  localparam logic [2:0] PSEL_S1   = 3'b010;
  localparam logic [2:0] PSEL_S2   = 3'b100;

  // Returns the one-hot slave select; PSEL_NONE marks an out-of-map address.
  function automatic logic [2:0] decode_psel(input logic [31:0] addr);
    if (addr >= SLV0_BASE && addr <= SLV0_LIMIT) return PSEL_S0;
    if (addr >= SLV1_BASE && addr <= SLV1_LIMIT) return PSEL_S1;
    if (addr >= SLV2_BASE && addr <= SLV2_LIMIT) return PSEL_S2;
    return PSEL_NONE;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Requester command/response and APB bus signals of the APB master sequencer.
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid, req1_valid;
  logic              req0_write, req1_write;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_ready, req1_ready;

  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  logic              penable;
  logic              pwrite;
  logic [2:0]        pselx;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  // The sequencer itself: owns the APB outputs and the requester responses.
  modport master (
    input  req0_valid, req1_valid, req0_write, req1_write,
           req0_addr, req1_addr, req0_wdata, req1_wdata, prdata, pready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
           penable, pwrite, pselx, paddr, pwdata
  );

  modport slave (
    output req0_valid, req1_valid, req0_write, req1_write,
           req0_addr, req1_addr, req0_wdata, req1_wdata, prdata, pready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
           penable, pwrite, pselx, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; the requester not granted last wins a contention.
module apb_rr_arbiter (
  input  logic       Hclk,
  input  logic       Hreset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Hclk) begin
    if (Hreset)                last_grant_q <= 1'b1;
    else if (accept && |grant) last_grant_q <= grant[1];
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer sharing one APB port between two requesters.
// Optional feature: define APB_PREADY_EN for pready wait states with a TIMEOUT abort.
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hreset,
  apb_master_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic [1:0]        req, grant;
  logic              accept;
  logic              sel_id, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_psel;

  logic              cmd_id_q, cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [2:0]        cmd_psel_q;

  logic              xfer_done, xfer_abort, rsp_done, rsp_fail;
  logic              rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // Requests are only visible to the arbiter while idle and out of reset.
  assign req = (state_q == ST_IDLE && !Hreset) ? {bus.req1_valid, bus.req0_valid} : 2'b00;

  apb_rr_arbiter u_arb (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  assign accept         = |grant;
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign sel_id    = grant[1];
  assign sel_write = sel_id ? bus.req1_write : bus.req0_write;
  assign sel_addr  = sel_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = sel_id ? bus.req1_wdata : bus.req0_wdata;
  assign sel_psel  = decode_psel(32'(sel_addr));

  // NOTE: the command latch carries no reset; it is only observed in SETUP/ACCESS/ERR.
  always_ff @(posedge Hclk) begin
    if (accept) begin
      cmd_id_q    <= sel_id;
      cmd_write_q <= sel_write;
      cmd_addr_q  <= sel_addr;
      cmd_wdata_q <= sel_wdata;
      cmd_psel_q  <= sel_psel;
    end
  end

`ifdef APB_PREADY_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge Hclk) begin
    if (Hreset)                                   wait_cnt_q <= '0;
    else if (state_q == ST_SETUP)                 wait_cnt_q <= '0;
    else if (state_q == ST_ACCESS && !bus.pready) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

  assign xfer_done  = bus.pready;
  assign xfer_abort = !bus.pready && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic pready_unused;
  assign pready_unused = bus.pready;
  assign xfer_done     = 1'b1;
  assign xfer_abort    = 1'b0;
`endif

  always_ff @(posedge Hclk) begin
    if (Hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pselx   = PSEL_NONE;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    rsp_done    = 1'b0;
    rsp_fail    = 1'b0;

    if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
      bus.pwrite = cmd_write_q;
      bus.pselx  = cmd_psel_q;
      bus.paddr  = cmd_addr_q;
      bus.pwdata = cmd_wdata_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (sel_psel == PSEL_NONE) ? ST_ERR : ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        bus.penable = 1'b1;
        if (xfer_done) begin
          state_d  = ST_IDLE;
          rsp_done = 1'b1;
        end else if (xfer_abort) begin
          state_d  = ST_IDLE;
          rsp_done = 1'b1;
          rsp_fail = 1'b1;
        end
      end
      ST_ERR: begin
        state_d  = ST_IDLE;
        rsp_done = 1'b1;
        rsp_fail = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response fields are zero whenever no completion is being reported.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_done;
      rsp_id_q    <= rsp_done & cmd_id_q;
      rsp_err_q   <= rsp_fail;
      rsp_rdata_q <= (rsp_done && !rsp_fail && !cmd_write_q) ? bus.prdata : '0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
